// File: rtl/c5_conv_sequencer_if.sv
// Signal bundle between the C5 layer sequencer (master) and its memories, datapath and result consumer (slave).
interface c5_conv_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  keep_weights;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [1:0]            mem_sel;
  logic [15:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  ld_valid;
  logic [1:0]            ld_sel;
  logic [15:0]           ld_idx;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  conv_rst;
  logic [6:0]            out_idx;
  logic [DATA_WIDTH-1:0] out_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  start, keep_weights, mem_rd_data, out_word, out_ready,
    output busy, done, mem_rd_en, mem_sel, mem_addr, ld_valid, ld_sel, ld_idx, ld_data,
           conv_rst, out_idx, out_valid, out_data
  );

  modport slave (
    output start, keep_weights, mem_rd_data, out_word, out_ready,
    input  busy, done, mem_rd_en, mem_sel, mem_addr, ld_valid, ld_sel, ld_idx, ld_data,
           conv_rst, out_idx, out_valid, out_data
  );
endinterface

// File: rtl/c5_conv_sequencer.sv
// C5 layer sequencer: streams image/filter/bias into the datapath, waits out the convolution, drains results.
// Optional weight reuse (skip filter/bias reload) is enabled by defining C5_SEQ_WEIGHT_CACHE_EN.
module c5_conv_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMG_WORDS    = 400,
  parameter int FLT_WORDS    = 48000,
  parameter int BIAS_WORDS   = 120,
  parameter int OUT_WORDS    = 120,
  parameter int CONV_LATENCY = 15681
) (
  input  logic                 clk,
  input  logic                 reset,
  c5_conv_sequencer_if.master  bus
);

  localparam int CNT_W = (CONV_LATENCY < 2) ? 1 : $clog2(CONV_LATENCY + 1);

  localparam logic [1:0]  SEL_IMG   = 2'd0;
  localparam logic [1:0]  SEL_FLT   = 2'd1;
  localparam logic [1:0]  SEL_BIAS  = 2'd2;
  localparam logic [15:0] IMG_LAST  = 16'(IMG_WORDS - 1);
  localparam logic [15:0] FLT_LAST  = 16'(FLT_WORDS - 1);
  localparam logic [15:0] BIAS_LAST = 16'(BIAS_WORDS - 1);
  localparam logic [6:0]  OUT_LAST  = 7'(OUT_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_IMG, LOAD_FLT, LOAD_BIAS, COMPUTE, DRAIN, DONE
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_mem_rd_en;
  logic [1:0]       r_mem_sel;
  logic [15:0]      r_mem_addr;
  logic             r_ld_valid;
  logic [1:0]       r_ld_sel;
  logic [15:0]      r_ld_idx;
  logic             r_conv_rst;
  logic [6:0]       r_out_idx;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_skip_wt;
  logic [DATA_WIDTH-1:0] w_out_word;

`ifdef C5_SEQ_WEIGHT_CACHE_EN
  logic r_wt_loaded;
  logic r_skip_wt;

  // The skip decision is frozen at start so it stays stable through LOAD_IMG.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wt_loaded <= 1'b0;
      r_skip_wt   <= 1'b0;
    end else begin
      if (r_state == LOAD_BIAS && r_mem_addr == BIAS_LAST) r_wt_loaded <= 1'b1;
      if (r_state == IDLE && bus.start) r_skip_wt <= bus.keep_weights && r_wt_loaded;
    end
  end
  assign w_skip_wt = r_skip_wt;
`else
  logic w_unused_keep;
  assign w_unused_keep = bus.keep_weights;
  assign w_skip_wt     = 1'b0;
`endif

  // NOTE: every register here uses <= so all updates see the pre-edge values, exactly like flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_sel   <= SEL_IMG;
      r_mem_addr  <= '0;
      r_ld_valid  <= 1'b0;
      r_ld_sel    <= SEL_IMG;
      r_ld_idx    <= '0;
      r_conv_rst  <= 1'b1;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_ld_valid <= r_mem_rd_en;
      r_ld_sel   <= r_mem_sel;
      r_ld_idx   <= r_mem_addr;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= LOAD_IMG;
            r_busy      <= 1'b1;
            r_mem_rd_en <= 1'b1;
            r_mem_sel   <= SEL_IMG;
            r_mem_addr  <= '0;
          end
        end
        LOAD_IMG: begin
          if (r_mem_addr != IMG_LAST) begin
            r_mem_addr <= r_mem_addr + 16'd1;
          end else if (w_skip_wt) begin
            r_state     <= COMPUTE;
            r_mem_rd_en <= 1'b0;
            r_mem_sel   <= SEL_IMG;
            r_mem_addr  <= '0;
            r_cnt       <= CNT_W'(CONV_LATENCY);
          end else begin
            r_state    <= LOAD_FLT;
            r_mem_sel  <= SEL_FLT;
            r_mem_addr <= '0;
          end
        end
        LOAD_FLT: begin
          if (r_mem_addr != FLT_LAST) begin
            r_mem_addr <= r_mem_addr + 16'd1;
          end else begin
            r_state    <= LOAD_BIAS;
            r_mem_sel  <= SEL_BIAS;
            r_mem_addr <= '0;
          end
        end
        LOAD_BIAS: begin
          if (r_mem_addr != BIAS_LAST) begin
            r_mem_addr <= r_mem_addr + 16'd1;
          end else begin
            r_state     <= COMPUTE;
            r_mem_rd_en <= 1'b0;
            r_mem_sel   <= SEL_IMG;
            r_mem_addr  <= '0;
            r_cnt       <= CNT_W'(CONV_LATENCY);
          end
        end
        COMPUTE: begin
          // conv_rst stays high on the entry cycle so the last operand write lands before release.
          r_conv_rst <= 1'b0;
          if (r_cnt == '0) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (r_out_idx == OUT_LAST) begin
              r_state     <= DONE;
              r_out_valid <= 1'b0;
              r_out_idx   <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_conv_rst  <= 1'b1;
            end else begin
              r_out_idx <= r_out_idx + 7'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_out_word    = bus.out_word;
  assign bus.out_data  = w_out_word;
  assign bus.ld_data   = bus.mem_rd_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.ld_valid  = r_ld_valid;
  assign bus.ld_sel    = r_ld_sel;
  assign bus.ld_idx    = r_ld_idx;
  assign bus.conv_rst  = r_conv_rst;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_c5_conv_sequencer.sv
// Scoreboard bench for c5_conv_sequencer: random memory/result contents, expected streams queued per pass.
module tb_c5_conv_sequencer;

  localparam int DW   = 16;
  localparam int IMG  = 4;
  localparam int FLT  = 6;
  localparam int BIAS = 2;
  localparam int OUTW = 2;
  localparam int CL   = 5;

  logic clk;
  logic reset;

  c5_conv_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  c5_conv_sequencer #(
    .DATA_WIDTH(DW), .IMG_WORDS(IMG), .FLT_WORDS(FLT), .BIAS_WORDS(BIAS),
    .OUT_WORDS(OUTW), .CONV_LATENCY(CL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit wt_loaded = 1'b0;

  logic [DW-1:0] img_mem  [IMG];
  logic [DW-1:0] flt_mem  [FLT];
  logic [DW-1:0] bias_mem [BIAS];
  logic [DW-1:0] result   [OUTW];

  logic [17:0]      exp_rd  [$];
  logic [17+DW:0]   exp_ld  [$];
  logic [6+DW:0]    exp_out [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [1:0] sel, input logic [15:0] addr);
    int a;
    a = int'(addr);
    case (sel)
      2'd0:    return (a < IMG)  ? img_mem[a]  : 16'hdead;
      2'd1:    return (a < FLT)  ? flt_mem[a]  : 16'hdead;
      2'd2:    return (a < BIAS) ? bias_mem[a] : 16'hdead;
      default: return 16'hdead;
    endcase
  endfunction

  // Source memories: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_sel, bus.mem_addr);
  end

  assign bus.out_word = (int'(bus.out_idx) < OUTW) ? result[int'(bus.out_idx)] : 16'hbeef;

  logic [17:0]    m_rd;
  logic [17+DW:0] m_ld;
  logic [6+DW:0]  m_out;

  always @(negedge clk) begin
    if (bus.mem_rd_en) begin
      if (exp_rd.size() == 0) check("rd_unexpected", {bus.mem_sel, bus.mem_addr}, 64'hffff_ffff);
      else begin
        m_rd = exp_rd.pop_front();
        check("rd_sel_addr", {bus.mem_sel, bus.mem_addr}, m_rd);
      end
    end
    if (bus.ld_valid) begin
      if (exp_ld.size() == 0) check("ld_unexpected", {bus.ld_sel, bus.ld_idx, bus.ld_data}, 64'hffff_ffff_ffff);
      else begin
        m_ld = exp_ld.pop_front();
        check("ld_sel_idx_data", {bus.ld_sel, bus.ld_idx, bus.ld_data}, m_ld);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_out.size() == 0) check("out_unexpected", {bus.out_idx, bus.out_data}, 64'hffff_ffff);
      else begin
        m_out = exp_out.pop_front();
        check("out_idx_data", {bus.out_idx, bus.out_data}, m_out);
      end
    end
  end

  // Reference: one pass reads every word of each loaded memory in order, then emits every result in order.
  task automatic push_expect(input bit skip);
    for (int i = 0; i < IMG; i++) begin
      img_mem[i] = DW'($urandom);
      exp_rd.push_back({2'd0, 16'(i)});
      exp_ld.push_back({2'd0, 16'(i), img_mem[i]});
    end
    if (!skip) begin
      for (int i = 0; i < FLT; i++) begin
        flt_mem[i] = DW'($urandom);
        exp_rd.push_back({2'd1, 16'(i)});
        exp_ld.push_back({2'd1, 16'(i), flt_mem[i]});
      end
      for (int i = 0; i < BIAS; i++) begin
        bias_mem[i] = DW'($urandom);
        exp_rd.push_back({2'd2, 16'(i)});
        exp_ld.push_back({2'd2, 16'(i), bias_mem[i]});
      end
    end
    for (int i = 0; i < OUTW; i++) begin
      result[i] = DW'($urandom);
      exp_out.push_back({7'(i), result[i]});
    end
  endtask

  // mode: 0 ready=1, 1 stall at idx 1, 2 random ready, 3 start held for the whole pass
  task automatic run_pass(input bit keep, input int mode);
    bit skip;
    int n, zc, m, exp_lat;
    logic [DW-1:0] saved, tmp;
    skip = 1'b0;
`ifdef C5_SEQ_WEIGHT_CACHE_EN
    skip = keep && wt_loaded;
`endif
    push_expect(skip);
    exp_lat = skip ? (IMG + CL + 2) : (IMG + FLT + BIAS + CL + 2);
    bus.keep_weights = keep;
    bus.start        = 1'b1;
    bus.out_ready    = 1'b1;
    n  = 0;
    zc = 0;
    while (n < 400 && !bus.out_valid) begin
      if (mode == 2) bus.out_ready = 1'($urandom);
      tick;
      n++;
      if (mode != 3) bus.start = 1'b0;
      if (!bus.out_valid && !bus.conv_rst) zc++;
    end
    check("first_valid_latency", n, exp_lat);
    check("conv_rst_low_cycles", zc, CL);
    check("busy_in_drain", bus.busy, 1);
    check("conv_rst_in_drain", bus.conv_rst, 0);
    if (mode == 1) begin
      tick;
      saved = result[1];
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tmp = DW'($urandom);
        result[1] = tmp;
        #1;
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_idx_held", bus.out_idx, 1);
        check("stall_data_tracks", bus.out_data, tmp);
        tick;
      end
      result[1] = saved;
      bus.out_ready = 1'b1;
      tick;
      check("done_after_ready", bus.done, 1);
    end else begin
      m = 0;
      while (m < 200 && !bus.done) begin
        if (mode == 2) bus.out_ready = 1'($urandom);
        tick;
        m++;
      end
      if (mode == 2) check("done_seen", bus.done, 1);
      else check("done_latency", m, OUTW);
    end
    check("busy_at_done", bus.busy, 0);
    tick;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    check("done_one_cycle", bus.done, 0);
    tick;
    check("idle_no_restart", {bus.busy, bus.mem_rd_en}, 0);
    check("scoreboard_drained", exp_rd.size() + exp_ld.size() + exp_out.size(), 0);
    if (!skip) wt_loaded = 1'b1;
  endtask

  task automatic reset_mid_load;
    int n;
    bit found;
    push_expect(1'b0);
    bus.keep_weights = 1'b0;
    bus.start = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 100 && !found) begin
      tick;
      n++;
      bus.start = 1'b0;
      if (bus.mem_rd_en && bus.mem_sel == 2'd1 && bus.mem_addr == 16'd3) found = 1'b1;
    end
    check("reached_flt_addr3", found, 1);
    reset = 1'b1;
    tick;
    check("midload_rst_busy", bus.busy, 0);
    check("midload_rst_rd_en", bus.mem_rd_en, 0);
    check("midload_rst_conv_rst", bus.conv_rst, 1);
    check("midload_rst_ld_valid", bus.ld_valid, 0);
    reset = 1'b0;
    exp_rd.delete();
    exp_ld.delete();
    exp_out.delete();
    wt_loaded = 1'b0;
    tick;
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.keep_weights = 1'b0;
    bus.out_ready    = 1'b1;
    tick;
    tick;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_sel", bus.mem_sel, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_ld_valid", bus.ld_valid, 0);
    check("rst_ld_sel", bus.ld_sel, 0);
    check("rst_ld_idx", bus.ld_idx, 0);
    check("rst_conv_rst", bus.conv_rst, 1);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_valid", bus.out_valid, 0);

    bus.start = 1'b1;
    tick;
    check("rst_over_start_busy", bus.busy, 0);
    check("rst_over_start_rd_en", bus.mem_rd_en, 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick;
    check("idle_after_rst", bus.busy, 0);

    run_pass(1'b0, 0);
    run_pass(1'b1, 0);
    run_pass(1'b0, 1);
    run_pass(1'b0, 3);
    reset_mid_load();
    run_pass(1'b1, 0);
    run_pass(1'b1, 0);
    for (int r = 0; r < 6; r++) run_pass(1'($urandom), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c5_conv_sequencer.md
C5_CONV_SEQUENCER -- requirements
Module: c5_conv_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: word width of all data ports.
REQ-002 The block SHALL have parameter IMG_WORDS, default 400: image words (16 ch x 5 x 5).
REQ-003 The block SHALL have parameter FLT_WORDS, default 48000: filter words (120 x 16 x 5 x 5).
REQ-004 The block SHALL have parameter BIAS_WORDS, default 120: bias words.
REQ-005 The block SHALL have parameter OUT_WORDS, default 120: result words.
REQ-006 The block SHALL have parameter CONV_LATENCY, default 15681: datapath cycles from conv_rst release to valid output.
REQ-007 The block SHALL have these ports, one clock domain, synchronous active-high reset:
 clk  in  1  rising-edge clock
 reset  in  1  synchronous, active-high
 start  in  1  begin one layer pass; sampled in IDLE only
 keep_weights  in  1  skip filter/bias reload (REQ-024)
 busy  out  1  pass in progress
 done  out  1  one-cycle pass-complete pulse
 mem_rd_en  out  1  source memory read strobe
 mem_sel  out  2  0=image, 1=filter, 2=bias
 mem_addr  out  16  word address within selected memory
 mem_rd_data  in  DATA_WIDTH  read data, valid 1 cycle after mem_rd_en
 ld_valid  out  1  ld_data to be written into datapath operand buffer
 ld_sel  out  2  buffer selector, same encoding as mem_sel
 ld_idx  out  16  word index within buffer
 ld_data  out  DATA_WIDTH  operand word
 conv_rst  out  1  reset to convolution datapath
 out_idx  out  7  result word select into datapath output bus
 out_word  in  DATA_WIDTH  datapath word at out_idx
 out_valid  out  1  out_data valid
 out_ready  in  1  downstream accepts out_data
 out_data  out  DATA_WIDTH  result stream word

Function
REQ-008 States SHALL be IDLE, LOAD_IMG, LOAD_FLT, LOAD_BIAS, COMPUTE, DRAIN, DONE.
REQ-009 IDLE with start=1 SHALL enter LOAD_IMG next cycle; start outside IDLE SHALL be ignored.
REQ-010 Each LOAD state SHALL assert mem_rd_en every cycle with mem_addr 0,1,...,N-1 (N = that state's word count) and the matching mem_sel.
REQ-011 After address N-1, next cycle SHALL be the following LOAD state at address 0 (no bubble); after LOAD_BIAS, COMPUTE.
REQ-012 ld_valid/ld_sel/ld_idx SHALL be the mem_rd_en/mem_sel/mem_addr of the previous cycle, registered; ld_data SHALL equal mem_rd_data.
REQ-013 conv_rst SHALL be 1 in IDLE, all LOAD states, DONE and the first COMPUTE cycle (the cycle carrying the final ld_valid); 0 otherwise.
REQ-014 COMPUTE SHALL last exactly CONV_LATENCY+1 cycles via a down-counter, then enter DRAIN.
REQ-015 DRAIN SHALL assert out_valid, drive out_data=out_word combinationally, start out_idx at 0, and increment out_idx only on out_valid&out_ready.
REQ-016 out_valid SHALL remain 1 and out_idx stable while out_ready=0.
REQ-017 Handshake at out_idx=OUT_WORDS-1 SHALL enter DONE; DONE SHALL last one cycle with done=1, then IDLE.
REQ-018 busy SHALL be 1 in LOAD_IMG through DRAIN, 0 in IDLE and DONE.
REQ-019 Total start-to-first-out_valid SHALL be 1+IMG_WORDS+FLT_WORDS+BIAS_WORDS+CONV_LATENCY+1 cycles (weights loaded).

Reset
REQ-020 reset=1 SHALL force IDLE from any state, including mid-load and mid-drain, at the next edge.
REQ-021 Reset values SHALL be: busy=0, done=0, mem_rd_en=0, mem_sel=0, mem_addr=0, ld_valid=0, ld_sel=0, ld_idx=0, conv_rst=1, out_idx=0, out_valid=0; weights-loaded flag cleared.
REQ-022 reset SHALL take priority over start in the same cycle.

Configuration
REQ-023 Macro C5_SEQ_WEIGHT_CACHE_EN SHALL select weight-reuse support.
REQ-024 With it defined: a flag SHALL set on completing LOAD_BIAS; start with keep_weights=1 and flag set SHALL go LOAD_IMG -> COMPUTE, skipping LOAD_FLT/LOAD_BIAS; flag clears on reset only.
REQ-025 Without it: keep_weights SHALL be ignored; every pass loads all three memories.

Verification (IMG_WORDS=4, FLT_WORDS=6, BIAS_WORDS=2, OUT_WORDS=2, CONV_LATENCY=5)
REQ-026 start pulse, out_ready=1 -> mem_addr 0..3 sel0, 0..5 sel1, 0..1 sel2 back-to-back; first out_valid 19 cycles after start; done 2 cycles later.
REQ-027 out_ready=0 for 3 cycles at out_idx=1 -> out_valid held, out_idx=1, out_data tracks out_word; done 1 cycle after ready returns.
REQ-028 reset asserted during LOAD_FLT addr 3 -> next cycle IDLE, busy=0, mem_rd_en=0, conv_rst=1.
REQ-029 start held high during COMPUTE and DONE -> no restart until IDLE observed; exactly one pass per IDLE-sampled start.
REQ-030 macro defined, second start with keep_weights=1 -> only 4 reads (sel0), first out_valid 11 cycles after start; macro undefined -> 12 reads.
